bitblaster_core_param: RTL and testbench

- Parametrised multi-cycle Bitblaster processor core: controller FSM, instruction register, N-entry register file and multi-stage ALU (A/G registers) in one block.
- Uses an internal multiplexed data bus instead of tri-state sharing.
- Instructions and load data arrive over a valid/ready handshake rather than raw switches.
- Sits between the input logic (debounced source) and the output logic (bus/timestep/done display).

---
 rtl/bitblaster_core_param.sv | 195 +++++++++++++++++++
 tb/tb_bitblaster_core_param.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bitblaster_core_param.sv
// Bitblaster multi-cycle core: FSM, IR, register file, A/G ALU.
// Internal muxed bus; instructions and ld data via valid/ready.
module bitblaster_core_param #(
  parameter int DATA_W   = 10,
  parameter int NUM_REGS = 4,
  parameter int RA_W     = $clog2(NUM_REGS)
) (
  input  logic              CLKb,
  input  logic              CLR,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RA_W-1:0]   peek_addr,
  output logic [DATA_W-1:0] peek_data,
  output logic [DATA_W-1:0] bus_out,
  output logic [1:0]        timestep,
  output logic              done,
  output logic              err,
  output logic              flag_z,
  output logic              flag_c
);

  localparam int IMM_W = DATA_W - 2 - RA_W;
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  logic [1:0]        st_q, st_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] g_q, g_d;
  logic              z_q, z_d;
  logic              c_q, c_d;
  logic [DATA_W-1:0] r_q [NUM_REGS];
  logic [DATA_W-1:0] r_d [NUM_REGS];

  logic [1:0]        cls;
  logic [RA_W-1:0]   rx, ry;
  logic [3:0]        fn;
  logic [DATA_W-1:0] imm;
  logic              is_ld, is_cp, is_one, is_two, is_imm;
  logic [DATA_W-1:0] bus, opb, alu_res;
  logic [DATA_W:0]   sum;
  logic              alu_c;
  logic              done_c, err_c, wr_en;

  // Instruction field decode and classification
  always_comb begin
    cls = ir_q[DATA_W-1 -: 2];
    rx  = ir_q[DATA_W-3 -: RA_W];
    ry  = ir_q[DATA_W-3-RA_W -: RA_W];
    fn  = ir_q[3:0];
    imm = '0;
    imm[IMM_W-1:0] = ir_q[IMM_W-1:0];
    is_ld  = (cls == 2'b00) && (fn == 4'b0000);
    is_cp  = (cls == 2'b00) && (fn == 4'b0001);
    is_one = (cls == 2'b00) && (fn == 4'b0100 || fn == 4'b0101);
    is_two = (cls == 2'b00) &&
             (fn == 4'b0010 || fn == 4'b0011 ||
              (fn >= 4'b0110 && fn <= 4'b1011));
    is_imm = cls[1];
  end

  // Second-stage ALU: A op (R[Ry] or imm)
  always_comb begin
    opb     = is_imm ? imm : r_q[ry];
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    if (cls == 2'b10 || (!is_imm && fn == 4'b0010)) begin
      sum     = {1'b0, a_q} + {1'b0, opb};
      alu_res = sum[DATA_W-1:0];
      alu_c   = sum[DATA_W];
    end else if (cls == 2'b11 || fn == 4'b0011) begin
      sum     = {1'b0, a_q} + {1'b0, ~opb} + {1'b0, ONE};
      alu_res = sum[DATA_W-1:0];
      alu_c   = sum[DATA_W];
    end else begin
      case (fn)
        4'b0110: alu_res = a_q & opb;
        4'b0111: alu_res = a_q | opb;
        4'b1000: alu_res = a_q ^ opb;
        4'b1001: alu_res = a_q << opb;
        4'b1010: alu_res = a_q >> opb;
        4'b1011: alu_res = $unsigned($signed(a_q) >>> opb);
        default: alu_res = '0;
      endcase
    end
  end

  // Controller: bus source, next state and register writes per step
  always_comb begin
    st_d     = st_q;
    ir_d     = ir_q;
    a_d      = a_q;
    g_d      = g_q;
    z_d      = z_q;
    c_d      = c_q;
    r_d      = r_q;
    bus      = '0;
    in_ready = 1'b0;
    done_c   = 1'b0;
    err_c    = 1'b0;
    wr_en    = 1'b0;
    case (st_q)
      T0: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bus  = in_data;
          ir_d = in_data;
          st_d = T1;
        end
      end
      T1: begin
        if (is_ld) begin
          in_ready = 1'b1;
          if (in_valid) begin
            bus   = in_data;
            wr_en = 1'b1;
          end
        end else if (is_cp) begin
          bus   = r_q[ry];
          wr_en = 1'b1;
        end else if (is_one) begin
          bus  = r_q[ry];
          g_d  = fn[0] ? ~bus : (~bus + ONE);
          z_d  = (g_d == '0);
          c_d  = 1'b0;
          st_d = T2;
        end else if (is_two || is_imm) begin
          bus  = r_q[rx];
          a_d  = bus;
          st_d = T2;
        end else begin
          err_c = 1'b1;
          st_d  = T0;
        end
      end
      T2: begin
        if (is_one) begin
          bus   = g_q;
          wr_en = 1'b1;
        end else begin
          bus  = opb;
          g_d  = alu_res;
          z_d  = (alu_res == '0);
          c_d  = alu_c;
          st_d = T3;
        end
      end
      default: begin
        bus   = g_q;
        wr_en = 1'b1;
      end
    endcase
    if (wr_en) begin
      r_d[rx] = bus;
      done_c  = 1'b1;
      st_d    = T0;
    end
  end

  // State update on the falling edge of the debounced clock
  always_ff @(negedge CLKb) begin
    if (CLR) begin
      st_q <= T0;
      ir_q <= '0;
      a_q  <= '0;
      g_q  <= '0;
      z_q  <= 1'b0;
      c_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_q[i] <= '0;
    end else begin
      st_q <= st_d;
      ir_q <= ir_d;
      a_q  <= a_d;
      g_q  <= g_d;
      z_q  <= z_d;
      c_q  <= c_d;
      for (int i = 0; i < NUM_REGS; i++) r_q[i] <= r_d[i];
    end
  end

  assign peek_data = r_q[peek_addr];
  assign bus_out   = bus;
  assign timestep  = st_q;
  assign done      = done_c & ~CLR;
  assign err       = err_c & ~CLR;
  assign flag_z    = z_q;
  assign flag_c    = c_q;

endmodule

// File: tb/tb_bitblaster_core_param.sv
// Directed bench for bitblaster_core_param (DATA_W=10, 4 regs).
// Inputs change just after the falling edge; outputs sampled later.
module tb_bitblaster_core_param;

  logic       CLKb = 1'b0;
  logic       CLR;
  logic [9:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] peek_addr;
  logic [9:0] peek_data;
  logic [9:0] bus_out;
  logic [1:0] timestep;
  logic       done, err, flag_z, flag_c;

  int checks = 0;
  int failures = 0;

  bitblaster_core_param #(.DATA_W(10), .NUM_REGS(4)) dut (
    .CLKb(CLKb), .CLR(CLR),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .peek_addr(peek_addr), .peek_data(peek_data),
    .bus_out(bus_out), .timestep(timestep),
    .done(done), .err(err),
    .flag_z(flag_z), .flag_c(flag_c)
  );

  always #5 CLKb = ~CLKb;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkreg(input string tag,
                        input logic [1:0] idx,
                        input logic [9:0] exp);
    peek_addr = idx;
    #1;
    chk(tag, {22'd0, peek_data}, {22'd0, exp});
  endtask

  // Fetch w (plus ld operand), count execute steps until done/err,
  // then let the final edge apply and check the return to T0.
  task automatic exec(input string tag,
                      input logic [9:0] w,
                      input logic [9:0] ldv,
                      input int exp_cyc,
                      input logic exp_err);
    int cyc;
    in_data  = w;
    in_valid = 1'b1;
    #1;
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    @(negedge CLKb); #1;
    in_valid = 1'b0;
    if (w[9:8] == 2'b00 && w[3:0] == 4'b0000) begin
      in_data  = ldv;
      in_valid = 1'b1;
    end
    #1;
    cyc = 1;
    while (!(done || err) && cyc < 8) begin
      @(negedge CLKb); #2;
      cyc++;
    end
    chk({tag, "_cyc"}, cyc, exp_cyc);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, "_done"}, {31'd0, done}, {31'd0, ~exp_err});
    @(negedge CLKb); #1;
    in_valid = 1'b0;
    chk({tag, "_t0"}, {30'd0, timestep}, 32'd0);
  endtask

  task automatic ld(input logic [1:0] rx, input logic [9:0] v);
    exec("ld", {2'b00, rx, 2'b00, 4'b0000}, v, 1, 1'b0);
  endtask

  initial begin
    CLR = 1'b1; in_data = '0; in_valid = 1'b0; peek_addr = '0;
    @(negedge CLKb); @(negedge CLKb); #1;
    chk("rst_done", {31'd0, done}, 32'd0);
    CLR = 1'b0;
    #1;
    chk("rst_ts", {30'd0, timestep}, 32'd0);
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_fz", {31'd0, flag_z}, 32'd0);
    chk("rst_fc", {31'd0, flag_c}, 32'd0);
    chk("rst_bus", {22'd0, bus_out}, 32'd0);
    chkreg("rst_r0", 2'd0, 10'h000);
    chkreg("rst_r3", 2'd3, 10'h000);

    ld(2'd0, 10'h005);
    chkreg("ld_r0", 2'd0, 10'h005);
    ld(2'd1, 10'h003);
    chkreg("ld_r1", 2'd1, 10'h003);
    exec("add", 10'h012, '0, 3, 1'b0);
    chkreg("add_r0", 2'd0, 10'h008);
    chk("add_c", {31'd0, flag_c}, 32'd0);
    chk("add_z", {31'd0, flag_z}, 32'd0);

    ld(2'd0, 10'h002);
    exec("sub", 10'h013, '0, 3, 1'b0);
    chkreg("sub_r0", 2'd0, 10'h3FF);
    chk("sub_c", {31'd0, flag_c}, 32'd0);
    chk("sub_z", {31'd0, flag_z}, 32'd0);

    ld(2'd0, 10'h03F);
    exec("subi", 10'h33F, '0, 3, 1'b0);
    chkreg("subi_r0", 2'd0, 10'h000);
    chk("subi_z", {31'd0, flag_z}, 32'd1);
    chk("subi_c", {31'd0, flag_c}, 32'd1);

    ld(2'd2, 10'h200);
    ld(2'd3, 10'h00C);
    exec("asr", 10'h0BB, '0, 3, 1'b0);
    chkreg("asr_r2", 2'd2, 10'h3FF);
    chk("asr_c", {31'd0, flag_c}, 32'd0);
    ld(2'd2, 10'h200);
    exec("lsr", 10'h0BA, '0, 3, 1'b0);
    chkreg("lsr_r2", 2'd2, 10'h000);
    chk("lsr_z", {31'd0, flag_z}, 32'd1);

    ld(2'd2, 10'h005);
    ld(2'd3, 10'h003);
    exec("lsl", 10'h0B9, '0, 3, 1'b0);
    chkreg("lsl_r2", 2'd2, 10'h028);

    ld(2'd0, 10'h201);
    exec("dbl", 10'h002, '0, 3, 1'b0);
    chkreg("dbl_r0", 2'd0, 10'h002);
    chk("dbl_c", {31'd0, flag_c}, 32'd1);

    exec("inv", 10'h044, '0, 2, 1'b0);
    chkreg("inv_r1", 2'd1, 10'h3FE);
    exec("flp", 10'h045, '0, 2, 1'b0);
    chkreg("flp_r1", 2'd1, 10'h3FD);

    for (int i = 0; i < 5; i++) begin
      @(negedge CLKb); #1;
      chk("stall_ts", {30'd0, timestep}, 32'd0);
      chk("stall_rdy", {31'd0, in_ready}, 32'd1);
    end
    chkreg("stall_r1", 2'd1, 10'h3FD);
    exec("cp", 10'h041, '0, 1, 1'b0);
    chkreg("cp_r1", 2'd1, 10'h002);

    exec("ill", 10'h00D, '0, 1, 1'b1);
    chkreg("ill_r0", 2'd0, 10'h002);
    chkreg("ill_r1", 2'd1, 10'h002);

    in_data  = 10'h012;
    in_valid = 1'b1;
    @(negedge CLKb); #1;
    in_valid = 1'b0;
    @(negedge CLKb); #1;
    chk("clr_t2", {30'd0, timestep}, 32'd2);
    CLR = 1'b1;
    #1;
    chk("clr_done", {31'd0, done}, 32'd0);
    @(negedge CLKb); #1;
    CLR = 1'b0;
    #1;
    chk("clr_ts", {30'd0, timestep}, 32'd0);
    chkreg("clr_r0", 2'd0, 10'h000);
    chkreg("clr_r1", 2'd1, 10'h000);
    chk("clr_c", {31'd0, flag_c}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
